// File: rtl/lcd_frame_arbiter.sv
// lcd_frame_arbiter: round-robin arbiter latching one of two 256-bit frames into held LCD line buffers (clock/reset, req0/frame0, req1/frame1 in; line1_buffer/line2_buffer, ack0/ack1, owner, busy out)
module lcd_frame_arbiter #(
  parameter int HOLD_CYCLES = 50000,
  parameter int CNT_W = $clog2(HOLD_CYCLES) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic [255:0] frame0,
  input  logic         req1,
  input  logic [255:0] frame1,
  output logic [127:0] line1_buffer,
  output logic [127:0] line2_buffer,
  output logic         ack0,
  output logic         ack1,
  output logic         owner,
  output logic         busy
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [127:0] SPACES = {16{8'h20}};
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic rr_ptr;
  logic w;
  logic [255:0] frame_w;
  assign w = (req0 && req1) ? rr_ptr : req1;
  assign frame_w = w ? frame1 : frame0;
  assign busy = (state == HOLD);
  always_ff @(posedge clock) begin
    if (reset) begin
      line1_buffer <= SPACES;
      line2_buffer <= SPACES;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      owner <= 1'b0;
      rr_ptr <= 1'b0;
      cnt <= '0;
      state <= IDLE;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == IDLE) begin
        if (req0 || req1) begin
          {line1_buffer, line2_buffer} <= frame_w;
          ack0 <= ~w;
          ack1 <= w;
          owner <= w;
          rr_ptr <= ~w;
          cnt <= CNT_W'(HOLD_CYCLES - 1);
          state <= HOLD;
        end
      end else if (cnt == '0) state <= IDLE;
      else cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// tb_lcd_frame_arbiter: directed self-checking bench for lcd_frame_arbiter with HOLD_CYCLES = 4
module tb_lcd_frame_arbiter;
  localparam logic [127:0] SP  = {16{8'h20}};
  localparam logic [127:0] L41 = {16{8'h41}};
  localparam logic [127:0] L42 = {16{8'h42}};
  localparam logic [127:0] L55 = {16{8'h55}};
  localparam logic [127:0] L66 = {16{8'h66}};
  logic clock = 1'b0, reset, req0, req1;
  logic [255:0] frame0, frame1;
  logic [127:0] line1_buffer, line2_buffer;
  logic ack0, ack1, owner, busy;
  int checks = 0, errors = 0;
  lcd_frame_arbiter #(.HOLD_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .req0(req0), .frame0(frame0), .req1(req1), .frame1(frame1),
    .line1_buffer(line1_buffer), .line2_buffer(line2_buffer), .ack0(ack0), .ack1(ack1),
    .owner(owner), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag, input logic [127:0] l1, input logic [127:0] l2,
                           input logic a0, input logic a1, input logic ow, input logic bz);
    chk({tag, ".line1"}, line1_buffer, l1);
    chk({tag, ".line2"}, line2_buffer, l2);
    chk({tag, ".ack0"}, 128'(ack0), 128'(a0));
    chk({tag, ".ack1"}, 128'(ack1), 128'(a1));
    chk({tag, ".owner"}, 128'(owner), 128'(ow));
    chk({tag, ".busy"}, 128'(busy), 128'(bz));
  endtask
  initial begin
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    frame0 = {L41, L41}; frame1 = {L55, L55};
    step(); chk_state("reset_a", SP, SP, 0, 0, 0, 0);
    step(); chk_state("reset_b", SP, SP, 0, 0, 0, 0);
    reset = 1'b0; req1 = 1'b0;
    step(); chk_state("single_grant", L41, L41, 1, 0, 0, 1);
    req0 = 1'b0; frame0 = {L42, L42};
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("single_hold", L41, L41, 0, 0, 0, 1);
    end
    step(); chk_state("single_end", L41, L41, 0, 0, 0, 0);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; frame0 = {L41, L41};
    step(); chk_state("contend_reset", SP, SP, 0, 0, 0, 0);
    reset = 1'b0;
    for (int g = 0; g < 4; g++) begin
      step();
      if (g[0]) chk_state("contend_grant1", L55, L55, 0, 1, 1, 1);
      else chk_state("contend_grant0", L41, L41, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
        step();
        chk("contend_ack_both", 128'(ack0 & ack1), 128'(0));
        chk("contend_ack0", 128'(ack0), 128'(0));
        chk("contend_busy", 128'(busy), 128'(i < 3));
      end
    end
    req0 = 1'b0;
    for (int g = 0; g < 3; g++) begin
      step(); chk_state("cont_grant", L55, L55, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
        step(); chk_state("cont_hold", L55, L55, 0, 0, 1, 1);
      end
      step(); chk_state("cont_gap", L55, L55, 0, 0, 1, 0);
    end
    step(); chk_state("rst_mid_grant", L55, L55, 0, 1, 1, 1);
    step(); chk("rst_mid_busy_before", 128'(busy), 128'(1));
    reset = 1'b1;
    step(); chk_state("rst_mid_reset", SP, SP, 0, 0, 0, 0);
    reset = 1'b0;
    step(); chk_state("rst_mid_regrant", L55, L55, 0, 1, 1, 1);
    req1 = 1'b0;
    step(); chk_state("withdraw_h1", L55, L55, 0, 0, 1, 1);
    req1 = 1'b1; frame1 = {L66, L66};
    step(); chk_state("withdraw_h2", L55, L55, 0, 0, 1, 1);
    req1 = 1'b0;
    step(); chk_state("withdraw_h3", L55, L55, 0, 0, 1, 1);
    step(); chk_state("withdraw_end", L55, L55, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("withdraw_idle", L55, L55, 0, 0, 1, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_frame_arbiter.md
# lcd_frame_arbiter

Shares the single `lcd_controller` line-buffer pair between two frame sources: requester 0, the CPU's special-function-register display frame, and requester 1, a debug frame such as a register dump of r0–r7. It sits between the datapath SFR outputs and `lcd_controller.line1_buffer`/`line2_buffer`. A granted frame is latched into registered line buffers and held for a minimum time so the LCD controller finishes a refresh before the content changes. When both requesters are waiting, grants alternate round-robin.

## Interface

Parameters:
- `HOLD_CYCLES`, default 50000: minimum number of clock cycles a latched frame is held (HOLD duration); legal range ≥ 1.
- `CNT_W`, default `$clog2(HOLD_CYCLES)+1`: width of the hold counter.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req0`  in  1: requester 0 (CPU SFR frame) wants the display; level-sensitive.
- `frame0`  in  256: requester 0 frame `{line1[127:0], line2[127:0]}`, 16 ASCII bytes per line, leftmost character in the MSB byte.
- `req1`  in  1: requester 1 (debug frame) request; level-sensitive.
- `frame1`  in  256: requester 1 frame, same format as `frame0`.
- `line1_buffer`  out  128: registered line 1, wired to `lcd_controller`.
- `line2_buffer`  out  128: registered line 2, wired to `lcd_controller`.
- `ack0`  out  1: one-cycle pulse; requester 0's frame was latched.
- `ack1`  out  1: one-cycle pulse; requester 1's frame was latched.
- `owner`  out  1: index of the requester whose frame is currently displayed.
- `busy`  out  1: high while in HOLD.

## Operation

- States:
  - IDLE: waiting for a request.
  - HOLD: counting down; no grants.
- IDLE, no request: stay in IDLE; all outputs unchanged except `ack0`/`ack1` = 0.
- IDLE, any `req` high at a rising edge, on that edge:
  - pick winner `w`.
  - `{line1_buffer, line2_buffer} <= frame_w`.
  - `ack_w <= 1`, the other ack `<= 0`.
  - `owner <= w`, `rr_ptr <= ~w`.
  - `cnt <= HOLD_CYCLES-1`, state `<= HOLD`.
- Winner selection:
  - Only one request: that requester wins.
  - Both requests: `w = rr_ptr`. `rr_ptr` resets to 0, so requester 0 wins the first tie.
- HOLD, each edge:
  - `ack0`, `ack1` `<= 0`.
  - If `cnt == 0`, state `<= IDLE`; otherwise `cnt <= cnt-1`.
  - Requests are ignored.
- Requester protocol:
  - Hold `req` high and `frame` stable until `ack` is seen.
  - Deassert `req` at or after the edge that samples `ack` high.
  - A request still high after the hold expires is granted again, so a continuous request means periodic refresh.
  - Dropping `req` before the grant edge withdraws it; this is legal.
- The frame is sampled only on the grant edge. Later changes to `frame_w` do not affect the buffers.
- `busy` is high exactly when state == HOLD.
- Counter width: `cnt` is `CNT_W` bits. Decrement never wraps because it stops at 0.

## Timing

- Reset values (on the first edge with `reset` = 1, regardless of state):
  - `line1_buffer` = `line2_buffer` = 128'h2020…20 (16 ASCII spaces).
  - `ack0` = `ack1` = 0.
  - `owner` = 0, `busy` = 0.
  - state = IDLE, `cnt` = 0, `rr_ptr` = 0.
- Reset asserted mid-HOLD: an immediate return to the reset values above; any pending grant is lost.
- Grant latency: a request sampled in IDLE at edge k updates the buffers at edge k. `ack` is high during cycle k→k+1.
- HOLD lasts exactly `HOLD_CYCLES` cycles. The earliest next grant is at edge k+`HOLD_CYCLES`+1.
- A request arriving on the same edge that HOLD ends (`cnt == 0`) is granted on the following edge.
- `req` rising simultaneously with reset deassertion: the first edge with `reset` = 0 can grant.

## Test plan

Simulate with `HOLD_CYCLES` = 4.

1. **Reset.** Assert `reset` for 2 cycles with `req0`/`req1` = 1. Required: buffers = all 0x20, `ack0` = `ack1` = 0, `busy` = 0, `owner` = 0 throughout.
2. **Single grant.** `req0` = 1, `frame0` = 32 bytes of 0x41, at edge k. Required:
   - `line1_buffer` = `line2_buffer` = 0x41 ×16 from edge k.
   - `ack0` high for exactly one cycle.
   - `busy` high for 4 cycles.
   - `frame0` changed to 0x42 at k+1 does not alter the buffers.
3. **Contention.** `req0` = `req1` = 1 held continuously from reset release. Required:
   - Grants alternate 0,1,0,1 at edges k, k+5, k+10, k+15.
   - `owner` toggles at each of those edges.
   - `ack0`/`ack1` are never both high.
4. **Continuous single request.** `req1` alone held high. Required: `ack1` pulses every 5 cycles, `owner` = 1, and `busy` is low for exactly 1 cycle between holds.
5. **Reset mid-hold.** Assert `reset` during the second HOLD cycle. Required:
   - Next edge: buffers = spaces, `busy` = 0, `owner` = 0.
   - With `req1` high after release, `req1` is granted on the first non-reset edge with no residual hold.
6. **Withdrawn request.** Pulse `req1` high for one cycle during HOLD, low before HOLD ends. Required: no `ack1` and buffers unchanged.
